// File: rtl/P65C816_pkg.sv
// Shared types and constants for the 65C816 processor status register:
// flag-operation encoding, reset value and flag bit positions.
package P65C816_pkg;

  typedef enum logic [2:0] {
    NOP       = 3'd0,
    ALU       = 3'd1,
    REP       = 3'd2,
    SEP       = 3'd3,
    LOAD      = 3'd4,
    XCE       = 3'd5,
    INT_ENTRY = 3'd6,
    RSVD      = 3'd7
  } FlagOp_t;

  localparam logic [7:0] P_RESET = 8'h34;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_X = 4;
  localparam int FLAG_M = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  // Mask order is {N,V,Z,C}; unmasked flags keep their current value.
  function automatic logic [7:0] alu_merge(input logic [7:0] p,
                                           input logic [3:0] mask,
                                           input logic       n,
                                           input logic       v,
                                           input logic       z,
                                           input logic       c);
    logic [7:0] r;
    r = p;
    if (mask[3]) r[FLAG_N] = n;
    if (mask[2]) r[FLAG_V] = v;
    if (mask[1]) r[FLAG_Z] = z;
    if (mask[0]) r[FLAG_C] = c;
    return r;
  endfunction

endpackage

// File: rtl/p_status_reg.sv
// 65C816 processor status register P with emulation flag E, effective IRQ mask
// and index-high-clear pulse. Optional macro P65_IRQ_DELAY_EN defers IRQ_MASK.
module p_status_reg
  import P65C816_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic [2:0] FLAG_OP,
  input  logic [3:0] FLAG_MASK,
  input  logic       ALU_N,
  input  logic       ALU_V,
  input  logic       ALU_Z,
  input  logic       ALU_C,
  input  logic [7:0] D_IN,
  input  logic       INSTR_END,
  output logic [7:0] P,
  output logic       E,
  output logic       IRQ_MASK,
  output logic       IDX_HI_CLR
);

  logic [7:0] r_p;
  logic       r_e;
  logic       r_irq_mask;
  logic       r_idx_hi_clr;

  logic [7:0] w_p_nxt;
  logic       w_e_nxt;
  logic       w_irq_nxt;
  logic       w_x_rise;
  FlagOp_t    w_op;

  assign w_op = FlagOp_t'(FLAG_OP);

  always_comb begin
    w_p_nxt = r_p;
    w_e_nxt = r_e;
    case (w_op)
      ALU:       w_p_nxt = alu_merge(r_p, FLAG_MASK, ALU_N, ALU_V, ALU_Z, ALU_C);
      REP:       w_p_nxt = r_p & ~D_IN;
      SEP:       w_p_nxt = r_p | D_IN;
      LOAD:      w_p_nxt = D_IN;
      XCE: begin
        w_p_nxt[FLAG_C] = r_e;
        w_e_nxt         = r_p[FLAG_C];
      end
      INT_ENTRY: begin
        w_p_nxt[FLAG_I] = 1'b1;
        w_p_nxt[FLAG_D] = 1'b0;
      end
      default:   w_p_nxt = r_p;
    endcase

    // Emulation mode pins M and X high after any update, including XCE entry.
    if (w_e_nxt) begin
      w_p_nxt[FLAG_M] = 1'b1;
      w_p_nxt[FLAG_X] = 1'b1;
    end

    w_x_rise = ~r_p[FLAG_X] & w_p_nxt[FLAG_X];

`ifdef P65_IRQ_DELAY_EN
    // CLI/SEI/PLP take effect on interrupt recognition only at instruction end.
    if (w_op == INT_ENTRY)
      w_irq_nxt = 1'b1;
    else if (INSTR_END)
      w_irq_nxt = w_p_nxt[FLAG_I];
    else
      w_irq_nxt = r_irq_mask;
`else
    w_irq_nxt = w_p_nxt[FLAG_I];
`endif
  end

`ifndef P65_IRQ_DELAY_EN
  logic w_unused_instr_end;
  assign w_unused_instr_end = INSTR_END;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_p          <= P_RESET;
      r_e          <= 1'b1;
      r_irq_mask   <= 1'b1;
      r_idx_hi_clr <= 1'b0;
    end else if (CE) begin
      r_p          <= w_p_nxt;
      r_e          <= w_e_nxt;
      r_irq_mask   <= w_irq_nxt;
      r_idx_hi_clr <= w_x_rise;
    end
  end

  assign P          = r_p;
  assign E          = r_e;
  assign IRQ_MASK   = r_irq_mask;
  assign IDX_HI_CLR = r_idx_hi_clr;

endmodule
